traffic_light_monitor: RTL and testbench

//   Safety stage directly downstream of the four-way traffic light controller. Samples the

---
 rtl/traffic_light_monitor.sv | 227 ++++++++++++++++++++++
 tb/tb_traffic_light_monitor.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_light_monitor.sv
// Safety monitor between the four-way light controller and the lamp drivers.
// Forwards aspects one cycle late; on the first rule violation latches a code and flashes red.
module traffic_light_monitor #(
   parameter int unsigned YEL_MIN    = 5,
   parameter int unsigned GRN_MIN    = 30,
   parameter int unsigned WDOG_MAX   = 64,
   parameter int unsigned FLASH_HALF = 8,
   parameter int unsigned CW         = 7
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] north_lights,
   input  logic [2:0] east_lights,
   input  logic [2:0] south_lights,
   input  logic [2:0] west_lights,
   input  logic       fault_clr,
   output logic [2:0] lamp_n,
   output logic [2:0] lamp_e,
   output logic [2:0] lamp_s,
   output logic [2:0] lamp_w,
   output logic       fault,
   output logic [2:0] fault_code,
   output logic       cycle_done
);

   localparam logic [2:0] RED  = 3'b100;
   localparam logic [2:0] YEL  = 3'b010;
   localparam logic [2:0] GRN  = 3'b001;
   localparam logic [2:0] DARK = 3'b000;

   localparam int unsigned FW = (FLASH_HALF > 1) ? $clog2(2 * FLASH_HALF) : 1;

   localparam logic [CW-1:0] YEL_MIN_C   = CW'(YEL_MIN);
   localparam logic [CW-1:0] GRN_MIN_C   = CW'(GRN_MIN);
   localparam logic [CW-1:0] WDOG_C      = CW'(WDOG_MAX);
   localparam logic [CW-1:0] WDOG_INIT_C = CW'(WDOG_MAX - 1);
   localparam logic [CW-1:0] DWELL_SAT   = '1;
   localparam logic [CW-1:0] DWELL_ONE   = CW'(1);
   localparam logic [FW-1:0] FLASH_LAST  = FW'(2 * FLASH_HALF - 1);
   localparam logic [FW-1:0] FLASH_HALFC = FW'(FLASH_HALF);

   typedef enum logic [1:0] {
      ST_INIT,
      ST_RUN,
      ST_FAULT
   } state_t;

   typedef enum logic [2:0] {
      FC_NONE     = 3'd0,
      FC_ENC      = 3'd1,
      FC_CONFLICT = 3'd2,
      FC_TRANS    = 3'd3,
      FC_DWELL    = 3'd4,
      FC_WDOG     = 3'd5
   } fcode_t;

   state_t        state_q, state_d;
   logic [2:0]    cur       [4];
   logic [2:0]    prev_q    [4];
   logic [2:0]    prev_d    [4];
   logic [2:0]    lamp_q    [4];
   logic [2:0]    lamp_d    [4];
   logic [CW-1:0] dwell_q, dwell_d;
   logic [FW-1:0] flash_q, flash_d, flash_nxt;
   logic          fault_q, fault_d;
   logic [2:0]    code_q, code_d;
   logic          cycle_done_q, cycle_done_d;

   logic          enc_bad, trans_bad, dwell_bad, all_red, same;
   logic [2:0]    nonred;
   fcode_t        viol_code;

   function automatic logic is_aspect(input logic [2:0] a);
      return (a == RED) || (a == YEL) || (a == GRN);
   endfunction

   function automatic logic illegal_step(input logic [2:0] p, input logic [2:0] c);
      return ((p == RED) && (c == GRN)) ||
             ((p == YEL) && (c == RED)) ||
             ((p == GRN) && (c == YEL));
   endfunction

   always_comb begin
      cur[0] = north_lights;
      cur[1] = east_lights;
      cur[2] = south_lights;
      cur[3] = west_lights;
   end

   // Rule checks of the current sample against the previously accepted one.
   always_comb begin : check_comb
      enc_bad   = 1'b0;
      trans_bad = 1'b0;
      dwell_bad = 1'b0;
      all_red   = 1'b1;
      same      = 1'b1;
      nonred    = '0;
      for (int unsigned i = 0; i < 4; i++) begin
         if (!is_aspect(cur[i[1:0]])) enc_bad = 1'b1;
         if (cur[i[1:0]] != RED) begin
            nonred  = nonred + 3'd1;
            all_red = 1'b0;
         end
         if (illegal_step(prev_q[i[1:0]], cur[i[1:0]])) trans_bad = 1'b1;
         if (cur[i[1:0]] != prev_q[i[1:0]]) begin
            same = 1'b0;
            if ((prev_q[i[1:0]] == YEL) && (dwell_q < YEL_MIN_C)) dwell_bad = 1'b1;
            if ((prev_q[i[1:0]] == GRN) && (dwell_q < GRN_MIN_C)) dwell_bad = 1'b1;
         end
      end

      viol_code = FC_NONE;
      if (enc_bad)                        viol_code = FC_ENC;
      else if (nonred > 3'd1)             viol_code = FC_CONFLICT;
      else if (trans_bad)                 viol_code = FC_TRANS;
      else if (dwell_bad)                 viol_code = FC_DWELL;
      else if (same && dwell_q == WDOG_C) viol_code = FC_WDOG;
   end

   always_ff @(posedge clk) begin : state_reg
      if (rst) state_q <= ST_INIT;
      else     state_q <= state_d;
   end

   always_comb begin : next_state_comb
      state_d = state_q;
      case (state_q)
         ST_INIT: begin
            if (all_red)                       state_d = ST_RUN;
            else if (dwell_q == WDOG_INIT_C)   state_d = ST_FAULT;
         end
         ST_RUN: begin
            if (viol_code != FC_NONE)          state_d = ST_FAULT;
         end
         ST_FAULT: begin
            if (fault_clr)                     state_d = ST_INIT;
         end
         default:                              state_d = ST_INIT;
      endcase
   end

   always_comb begin : output_comb
      lamp_d       = lamp_q;
      prev_d       = prev_q;
      dwell_d      = dwell_q;
      flash_d      = flash_q;
      fault_d      = fault_q;
      code_d       = code_q;
      cycle_done_d = 1'b0;
      flash_nxt    = (flash_q == FLASH_LAST) ? '0 : flash_q + FW'(1);

      case (state_q)
         ST_INIT: begin
            lamp_d = '{default: RED};
            if (all_red) begin
               prev_d  = cur;
               dwell_d = DWELL_ONE;
            end else if (dwell_q == WDOG_INIT_C) begin
               fault_d = 1'b1;
               code_d  = FC_WDOG;
               flash_d = '0;
            end else begin
               dwell_d = dwell_q + DWELL_ONE;
            end
         end
         ST_RUN: begin
            if (viol_code != FC_NONE) begin
               fault_d = 1'b1;
               code_d  = viol_code;
               lamp_d  = '{default: RED};
               flash_d = '0;
            end else begin
               lamp_d       = cur;
               prev_d       = cur;
               dwell_d      = !same ? DWELL_ONE :
                              (dwell_q == DWELL_SAT) ? dwell_q : dwell_q + DWELL_ONE;
               cycle_done_d = (prev_q[3] == GRN) && (cur[3] == RED);
            end
         end
         ST_FAULT: begin
            if (fault_clr) begin
               fault_d = 1'b0;
               code_d  = FC_NONE;
               lamp_d  = '{default: RED};
               prev_d  = '{default: RED};
               dwell_d = '0;
               flash_d = '0;
            end else begin
               flash_d = flash_nxt;
               lamp_d  = (flash_nxt < FLASH_HALFC) ? '{default: RED} : '{default: DARK};
            end
         end
         default: begin
            lamp_d = '{default: RED};
         end
      endcase
   end

   always_ff @(posedge clk) begin : data_reg
      if (rst) begin
         lamp_q       <= '{default: RED};
         prev_q       <= '{default: RED};
         dwell_q      <= '0;
         flash_q      <= '0;
         fault_q      <= 1'b0;
         code_q       <= '0;
         cycle_done_q <= 1'b0;
      end else begin
         lamp_q       <= lamp_d;
         prev_q       <= prev_d;
         dwell_q      <= dwell_d;
         flash_q      <= flash_d;
         fault_q      <= fault_d;
         code_q       <= code_d;
         cycle_done_q <= cycle_done_d;
      end
   end

   assign lamp_n     = lamp_q[0];
   assign lamp_e     = lamp_q[1];
   assign lamp_s     = lamp_q[2];
   assign lamp_w     = lamp_q[3];
   assign fault      = fault_q;
   assign fault_code = code_q;
   assign cycle_done = cycle_done_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Bench for traffic_light_monitor: directed scenarios plus randomized controller traffic,
// checked every cycle against a rule-level model of the monitor.
module tb_traffic_light_monitor;

   localparam logic [2:0]  R    = 3'b100;
   localparam logic [2:0]  Y    = 3'b010;
   localparam logic [2:0]  G    = 3'b001;
   localparam logic [11:0] ALLR = {R, R, R, R};

   logic       clk = 1'b0;
   logic       rst, fault_clr;
   logic [2:0] n_in, e_in, s_in, w_in;
   logic [2:0] lamp_n, lamp_e, lamp_s, lamp_w, fault_code;
   logic       fault, cycle_done;

   int vectors     = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   traffic_light_monitor #(
      .YEL_MIN(5), .GRN_MIN(30), .WDOG_MAX(64), .FLASH_HALF(8), .CW(7)
   ) dut (
      .clk(clk), .rst(rst),
      .north_lights(n_in), .east_lights(e_in), .south_lights(s_in), .west_lights(w_in),
      .fault_clr(fault_clr),
      .lamp_n(lamp_n), .lamp_e(lamp_e), .lamp_s(lamp_s), .lamp_w(lamp_w),
      .fault(fault), .fault_code(fault_code), .cycle_done(cycle_done)
   );

   // Model: mode 0 = waiting for all-red, 1 = monitoring, 2 = faulted.
   int          m_mode;
   int          m_cnt;
   int          m_age;
   logic [11:0] m_prev, m_lamp;
   logic        m_fault, m_cd;
   logic [2:0]  m_code;

   function automatic logic [2:0] asp(input logic [11:0] v, input int d);
      return v[11 - 3 * d -: 3];
   endfunction

   function automatic logic [11:0] put(input logic [11:0] v, input int d, input logic [2:0] a);
      logic [11:0] r;
      r = v;
      r[11 - 3 * d -: 3] = a;
      return r;
   endfunction

   function automatic int rule_code(input logic [11:0] in);
      int n;
      logic [2:0] p, c;
      for (int d = 0; d < 4; d++)
         if (!(asp(in, d) inside {R, Y, G})) return 1;
      n = 0;
      for (int d = 0; d < 4; d++)
         if (asp(in, d) != R) n++;
      if (n > 1) return 2;
      for (int d = 0; d < 4; d++) begin
         p = asp(m_prev, d);
         c = asp(in, d);
         if (!(p == c || (p == R && c == Y) || (p == Y && c == G) || (p == G && c == R)))
            return 3;
      end
      for (int d = 0; d < 4; d++) begin
         p = asp(m_prev, d);
         c = asp(in, d);
         if (p != c && ((p == Y && m_cnt < 5) || (p == G && m_cnt < 30))) return 4;
      end
      if (in == m_prev && m_cnt == 64) return 5;
      return 0;
   endfunction

   task automatic go_fault(input int c);
      m_mode  = 2;
      m_fault = 1'b1;
      m_code  = 3'(c);
      m_lamp  = ALLR;
      m_age   = 0;
   endtask

   task automatic model_step(input logic [11:0] in, input logic clr, input logic r);
      int c;
      if (r) begin
         m_mode = 0; m_lamp = ALLR; m_fault = 1'b0; m_code = '0; m_cd = 1'b0;
         m_cnt = 0; m_prev = ALLR; m_age = 0;
      end else begin
         m_cd = 1'b0;
         case (m_mode)
            0: begin
               m_lamp = ALLR;
               if (in == ALLR) begin
                  m_mode = 1; m_prev = in; m_cnt = 1;
               end else begin
                  m_cnt++;
                  if (m_cnt >= 64) go_fault(5);
               end
            end
            1: begin
               c = rule_code(in);
               if (c != 0) go_fault(c);
               else begin
                  m_cd   = (asp(m_prev, 3) == G) && (asp(in, 3) == R);
                  m_lamp = in;
                  m_cnt  = (in == m_prev) ? ((m_cnt < 127) ? m_cnt + 1 : 127) : 1;
                  m_prev = in;
               end
            end
            default: begin
               if (clr) begin
                  m_mode = 0; m_fault = 1'b0; m_code = '0; m_lamp = ALLR;
                  m_cnt = 0; m_prev = ALLR;
               end else begin
                  m_age++;
                  m_lamp = (((m_age / 8) % 2) == 0) ? ALLR : 12'h000;
               end
            end
         endcase
      end
   endtask

   task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic compare();
      check("lamps", {lamp_n, lamp_e, lamp_s, lamp_w}, m_lamp);
      check("fault", {11'd0, fault}, {11'd0, m_fault});
      check("fault_code", {9'd0, fault_code}, {9'd0, m_code});
      check("cycle_done", {11'd0, cycle_done}, {11'd0, m_cd});
   endtask

   task automatic step(input logic [11:0] in, input logic clr, input logic r);
      {n_in, e_in, s_in, w_in} = in;
      fault_clr = clr;
      rst = r;
      @(posedge clk);
      model_step(in, clr, r);
      #1;
      compare();
   endtask

   task automatic hold(input logic [11:0] in, input int n);
      for (int k = 0; k < n; k++) step(in, 1'b0, 1'b0);
   endtask

   int          gd, gph, grem;
   logic [11:0] gv, v;
   logic        clr_r, rst_r;

   initial begin
      // Reset and one full legal rotation.
      step(ALLR, 1'b0, 1'b1);
      step(ALLR, 1'b0, 1'b1);
      check("lit_reset_lamps", {lamp_n, lamp_e, lamp_s, lamp_w}, 12'h924);
      check("lit_reset_code", {9'd0, fault_code}, 12'd0);
      hold(ALLR, 10);
      for (int d = 0; d < 4; d++) begin
         hold(put(ALLR, d, Y), 5);
         hold(put(ALLR, d, G), 30);
         step(ALLR, 1'b0, 1'b0);
         if (d == 3) check("lit_cycle_done", {11'd0, cycle_done}, 12'd1);
         hold(ALLR, 4);
      end
      check("lit_no_fault", {11'd0, fault}, 12'd0);

      // Conflict, then flash cadence.
      step(put(put(ALLR, 0, G), 1, Y), 1'b0, 1'b0);
      check("lit_conflict_code", {9'd0, fault_code}, 12'd2);
      hold(ALLR, 7);
      check("lit_flash_red", {lamp_n, lamp_e, lamp_s, lamp_w}, 12'h924);
      step(ALLR, 1'b0, 1'b0);
      check("lit_flash_dark", {lamp_n, lamp_e, lamp_s, lamp_w}, 12'h000);
      hold(ALLR, 12);
      step(ALLR, 1'b1, 1'b0);
      check("lit_clr_code", {9'd0, fault_code}, 12'd0);
      hold(ALLR, 3);
      step(ALLR, 1'b1, 1'b0);
      hold(ALLR, 2);

      // Illegal transition and encoding priority.
      step(put(ALLR, 0, G), 1'b0, 1'b0);
      check("lit_trans_code", {9'd0, fault_code}, 12'd3);
      step(ALLR, 1'b1, 1'b0);
      hold(ALLR, 3);
      step({3'b110, G, R, R}, 1'b0, 1'b0);
      check("lit_enc_code", {9'd0, fault_code}, 12'd1);

      // Short yellow, short green.
      step(ALLR, 1'b1, 1'b0);
      hold(ALLR, 2);
      hold(put(ALLR, 0, Y), 3);
      step(put(ALLR, 0, G), 1'b0, 1'b0);
      check("lit_short_yel", {9'd0, fault_code}, 12'd4);
      step(ALLR, 1'b1, 1'b0);
      hold(ALLR, 2);
      hold(put(ALLR, 0, Y), 5);
      hold(put(ALLR, 0, G), 29);
      step(ALLR, 1'b0, 1'b0);
      check("lit_short_grn", {9'd0, fault_code}, 12'd4);

      // RUN watchdog.
      step(ALLR, 1'b1, 1'b0);
      hold(ALLR, 2);
      hold(put(ALLR, 0, Y), 5);
      hold(put(ALLR, 0, G), 64);
      check("lit_wdog_pending", {11'd0, fault}, 12'd0);
      step(put(ALLR, 0, G), 1'b0, 1'b0);
      check("lit_wdog_code", {9'd0, fault_code}, 12'd5);

      // Reset during fault; INIT watchdog; reset over clear.
      hold(ALLR, 3);
      step(ALLR, 1'b0, 1'b1);
      check("lit_rst_fault", {11'd0, fault}, 12'd0);
      hold(put(ALLR, 0, Y), 63);
      check("lit_init_pending", {11'd0, fault}, 12'd0);
      step(put(ALLR, 0, Y), 1'b0, 1'b0);
      check("lit_init_wdog", {9'd0, fault_code}, 12'd5);
      step(ALLR, 1'b1, 1'b1);
      hold(ALLR, 2);

      // Randomized controller traffic with occasional faults, clears and resets.
      gd = 0; gph = 0; grem = 4;
      for (int k = 0; k < 5000; k++) begin
         clr_r = ($urandom_range(0, 29) == 0);
         rst_r = ($urandom_range(0, 799) == 0);
         if (m_mode == 2) begin
            if ($urandom_range(0, 7) == 0) begin
               clr_r = 1'b1; gph = 0; gd = 0; grem = $urandom_range(1, 6);
            end
            v = 12'($urandom);
         end else begin
            case (gph)
               0:       gv = ALLR;
               1:       gv = put(ALLR, gd, Y);
               default: gv = put(ALLR, gd, G);
            endcase
            v = gv;
            case ($urandom_range(0, 199))
               0:       v = 12'($urandom);
               1:       v = put(gv, gd, 3'b001 << $urandom_range(0, 2));
               2:       v = put(gv, (gd + 1) % 4, Y);
               default: ;
            endcase
            grem--;
            if (grem <= 0) begin
               case (gph)
                  0: begin gph = 1; grem = $urandom_range(3, 7); end
                  1: begin gph = 2; grem = $urandom_range(27, 68); end
                  default: begin gph = 0; gd = (gd + 1) % 4; grem = $urandom_range(1, 8); end
               endcase
            end
         end
         if (rst_r) begin gph = 0; gd = 0; grem = 3; end
         step(v, clr_r, rst_r);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
